// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART transmit arbiter: serializer state
//   encoding, frame geometry, default oversampling factor, and the
//   round-robin pick used by the arbiter.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_NUM_REQ    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

  // Two-way round robin: on a tie the source that did not win last time
  // goes next; otherwise whichever source has data.
  function automatic logic rr_pick(input logic [1:0] nonempty, input logic last_grant);
    logic pick;
    if (&nonempty) pick = ~last_grant;
    else           pick = nonempty[1];
    return pick;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo
//   Synchronous byte FIFO, DEPTH entries (power of two, >= 2).
//   Ports:
//     clk, Rst    clock, asynchronous active-high reset (flushes contents)
//     push, din   write strobe and data; ignored while full
//     pop         read strobe; ignored while empty
//     dout        head-of-queue byte (combinational read)
//     full/empty  status derived from the registered count
//     count       occupancy, clog2(DEPTH)+1 bits
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     Rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART tx line between two byte sources (0: MMIO data
//   register, 1: debug/bootloader echo). Each source feeds its own
//   byte_fifo; a round-robin arbiter loads the shift register while idle
//   and an 8N1 serializer paced by a 16x baud tick drives the line.
//   Ports:
//     clk, Rst               system clock, asynchronous active-high reset
//     baud_tick              one-clk pulse at OVERSAMPLE x baud
//     reqN_valid/data/ready  per-source byte push, ready = FIFO not full
//     tx                     serial line, idle high, registered
//     busy                   frame in progress
//     grant_id               source of the current/last frame
//     done                   one-clk pulse when the stop bit ends
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       baud_tick,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id,
  output logic       done
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int NR = UART_NUM_REQ;

  // ---------------------------------------------------------------
  // Per-source FIFOs
  // ---------------------------------------------------------------
  logic [NR-1:0]         w_valid;
  logic [NR-1:0][7:0]    w_din;
  logic [NR-1:0][7:0]    w_dout;
  logic [NR-1:0]         w_push;
  logic [NR-1:0]         w_pop;
  logic [NR-1:0]         w_full;
  logic [NR-1:0]         w_empty;
  logic [NR-1:0][CW-1:0] w_count;

  assign w_valid = {req1_valid, req0_valid};
  assign w_din   = {req1_data, req0_data};
  assign w_push  = w_valid & ~w_full;

  assign req0_ready = ~w_full[0];
  assign req1_ready = ~w_full[1];

  for (genvar g = 0; g < NR; g++) begin : g_fifo
    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .Rst   (Rst),
      .push  (w_push[g]),
      .din   (w_din[g]),
      .pop   (w_pop[g]),
      .dout  (w_dout[g]),
      .full  (w_full[g]),
      .empty (w_empty[g]),
      .count (w_count[g])
    );
  end

  // ---------------------------------------------------------------
  // Arbiter + serializer FSM
  // ---------------------------------------------------------------
  uart_tx_state_e r_state;
  uart_tx_state_e w_state_nxt;
  logic [TW-1:0]  r_tick_cnt;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic           r_tx;
  logic           r_grant_id;
  logic           r_last_grant;
  logic           r_done;

  logic           w_tick_wrap;
  logic           w_grant_fire;
  logic           w_gnt;
  logic [NR-1:0]  w_nonempty;

  assign w_nonempty  = ~w_empty;
  assign w_tick_wrap = baud_tick && (r_tick_cnt == TW'(OVERSAMPLE - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = '0;
    w_grant_fire = 1'b0;
    w_gnt        = r_grant_id;
    case (r_state)
      IDLE: begin
        if (|w_nonempty) begin
          w_grant_fire = 1'b1;
          w_gnt        = rr_pick(w_nonempty, r_last_grant);
          w_pop[w_gnt] = 1'b1;
          w_state_nxt  = START;
        end
      end
      START: if (w_tick_wrap) w_state_nxt = DATA;
      DATA:  if (w_tick_wrap && (r_bit_idx == 3'(UART_DATA_BITS - 1))) w_state_nxt = STOP;
      STOP:  if (w_tick_wrap) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_state      <= IDLE;
      r_tick_cnt   <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_tx         <= 1'b1;
      r_grant_id   <= 1'b0;
      r_last_grant <= 1'b1;
      r_done       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == STOP) && w_tick_wrap;

      // Line follows the state one clk later, so the start bit appears on
      // the edge after the grant.
      case (r_state)
        START:   r_tx <= 1'b0;
        DATA:    r_tx <= r_shift[0];
        default: r_tx <= 1'b1;
      endcase

      if (w_grant_fire) begin
        r_shift      <= w_dout[w_gnt];
        r_grant_id   <= w_gnt;
        r_last_grant <= w_gnt;
      end else if ((r_state == DATA) && w_tick_wrap) begin
        r_shift <= r_shift >> 1;
      end

      // Ticks are counted only while a frame is in flight; every state
      // change restarts the count.
      if (w_state_nxt != r_state)                  r_tick_cnt <= '0;
      else if (w_tick_wrap)                        r_tick_cnt <= '0;
      else if ((r_state != IDLE) && baud_tick)     r_tick_cnt <= r_tick_cnt + 1'b1;

      if (r_state != DATA)  r_bit_idx <= '0;
      else if (w_tick_wrap) r_bit_idx <= r_bit_idx + 1'b1;
    end
  end

  assign tx       = r_tx;
  assign busy     = (r_state != IDLE);
  assign grant_id = r_grant_id;
  assign done     = r_done;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int OS = 16;
  localparam int FRAME_TICKS = 10 * OS;

  logic       clk = 1'b0;
  logic       Rst = 1'b1;
  logic       baud_tick;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data  = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data  = 8'h00;
  logic       req1_ready;
  logic       tx;
  logic       busy;
  logic       grant_id;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  int tick_period = 0;
  int tdiv        = 0;

  int         ft       = 0;
  int         done_cnt = 0;
  logic [9:0] rxv      = '0;
  logic [7:0] rx_q [$];
  logic       gid_q[$];

  uart_tx_arbiter #(.DEPTH(4), .OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .Rst        (Rst),
    .baud_tick  (baud_tick),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx         (tx),
    .busy       (busy),
    .grant_id   (grant_id),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
    chk("done_within_budget", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic expect_rx(input string tag, input logic [7:0] b, input logic gid);
    logic [7:0] got;
    logic       g;
    if (rx_q.size() == 0) begin
      chk({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      got = rx_q.pop_front();
      g   = gid_q.pop_front();
      chk({tag, "_byte"}, 32'(got), 32'(b));
      chk({tag, "_grant"}, 32'(g), 32'(gid));
    end
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    Rst = 1'b1;
    step();
    step();
    Rst = 1'b0;
    step();
  endtask

  // Baud tick generator: one-clk pulse every tick_period clks, 0 = stalled.
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_period == 0) begin
        baud_tick = 1'b0;
      end else begin
        tdiv++;
        if (tdiv >= tick_period) begin
          tdiv = 0;
          baud_tick = 1'b1;
        end else begin
          baud_tick = 1'b0;
        end
      end
    end
  end

  // Line receiver: counts ticks consumed during a frame and samples tx at
  // the middle of each bit; checks framing and length when done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (Rst) begin
        ft  = 0;
        rxv = '0;
      end else begin
        if (done) begin
          chk("start_bit", 32'(rxv[0]), 32'd0);
          chk("stop_bit", 32'(rxv[9]), 32'd1);
          chk("frame_ticks", 32'(ft), 32'(FRAME_TICKS));
          rx_q.push_back(rxv[8:1]);
          gid_q.push_back(grant_id);
          done_cnt++;
          ft  = 0;
          rxv = '0;
        end
        if (busy && baud_tick) begin
          ft++;
          if (ft >= OS/2 && ((ft - OS/2) % OS) == 0 && ((ft - OS/2) / OS) < 10)
            rxv[(ft - OS/2) / OS] = tx;
        end
      end
    end
  end

  initial begin
    int d0;
    int bad;
    int budget;

    // ---------------- reset state ----------------
    step();
    step();
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_last_grant", 32'(dut.r_last_grant), 32'd1);
    chk("rst_ready0", 32'(req0_ready), 32'd1);
    chk("rst_ready1", 32'(req1_ready), 32'd1);
    #1;
    Rst = 1'b0;
    step();

    // ---------------- single byte 0x61, tick every 10 clk ----------------
    tick_period = 10;
    req0_data  = 8'h61;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("lat_busy_after_push", 32'(busy), 32'd0);
    chk("lat_count_after_push", 32'(dut.w_count[0]), 32'd1);
    @(negedge clk);
    chk("lat_busy_after_grant", 32'(busy), 32'd1);
    chk("lat_count_after_grant", 32'(dut.w_count[0]), 32'd0);
    chk("lat_tx_at_grant", 32'(tx), 32'd1);
    @(negedge clk);
    chk("lat_tx_falls", 32'(tx), 32'd0);
    wait_done(1, 2000);
    expect_rx("single", 8'h61, 1'b0);
    @(negedge clk);
    chk("single_done_one_cycle", 32'(done), 32'd0);

    // ---------------- contention ----------------
    do_reset();
    tick_period = 4;
    d0 = done_cnt;
    req0_data = "a"; req1_data = "c";
    req0_valid = 1'b1; req1_valid = 1'b1;
    step();
    req0_data = "b"; req1_data = "d";
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_done(d0 + 4, 4000);
    expect_rx("cont0", "a", 1'b0);
    expect_rx("cont1", "c", 1'b1);
    expect_rx("cont2", "b", 1'b0);
    expect_rx("cont3", "d", 1'b1);

    // ---------------- full / backpressure ----------------
    step();
    step();
    tick_period = 0;
    d0 = done_cnt;
    req1_data  = 8'h10;
    req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    step();
    @(negedge clk);
    chk("bp_first_in_shift", 32'(busy), 32'd1);
    chk("bp_fifo_empty", 32'(dut.w_count[1]), 32'd0);
    #1;
    step();
    for (int i = 0; i < 4; i++) begin
      req1_data  = 8'(8'h11 + i);
      req1_valid = 1'b1;
      step();
      req1_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("bp_ready_after_push%0d", i + 1), 32'(req1_ready), 32'(i < 3));
      #1;
      step();
    end
    req1_data  = 8'h15;
    req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_refused_count", 32'(dut.w_count[1]), 32'd4);
    #1;
    tick_period = 4;
    wait_done(d0 + 5, 5 * FRAME_TICKS * 4 + 200);
    for (int i = 0; i < 5; i++)
      expect_rx($sformatf("bp%0d", i), 8'(8'h10 + i), 1'b1);
    for (int i = 0; i < 20; i++) @(negedge clk);
    chk("bp_ready_recovered", 32'(req1_ready), 32'd1);
    chk("bp_no_extra_frame", 32'(done_cnt), 32'(d0 + 5));

    // ---------------- simultaneous push/pop ----------------
    #1;
    d0 = done_cnt;
    req0_data  = 8'h5A;
    req0_valid = 1'b1;
    step();
    req0_data  = 8'hA5;
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("pp_count_held", 32'(dut.w_count[0]), 32'd1);
    chk("pp_busy", 32'(busy), 32'd1);
    wait_done(d0 + 2, 2 * FRAME_TICKS * 4 + 200);
    expect_rx("pp0", 8'h5A, 1'b0);
    expect_rx("pp1", 8'hA5, 1'b0);
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("pp_no_dup", 32'(done_cnt), 32'(d0 + 2));

    // ---------------- reset mid-frame ----------------
    #1;
    req0_data  = 8'h3C;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    step();
    req0_data  = 8'h88;
    req1_data  = 8'h77;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("rm_queued0", 32'(dut.w_count[0]), 32'd1);
    chk("rm_queued1", 32'(dut.w_count[1]), 32'd1);
    budget = 0;
    while (ft < OS + 3 * OS + OS/2 && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    chk("rm_reached_bit3", 32'(ft >= OS + 3 * OS + OS/2), 32'd1);
    d0 = done_cnt;
    #2;
    Rst = 1'b1;
    #1;
    chk("rm_tx_async", 32'(tx), 32'd1);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_flush0", 32'(dut.w_count[0]), 32'd0);
    chk("rm_flush1", 32'(dut.w_count[1]), 32'd0);
    step();
    step();
    Rst = 1'b0;
    step();
    req0_data  = 8'hC3;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    wait_done(d0 + 1, FRAME_TICKS * 4 + 200);
    expect_rx("rm_after", 8'hC3, 1'b0);
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("rm_no_dropped_frame_done", 32'(done_cnt), 32'(d0 + 1));

    // ---------------- idle gating ----------------
    tick_period = 1;
    d0  = done_cnt;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("idle_tx_high", 32'(bad), 32'd0);
    chk("idle_no_done", 32'(done_cnt), 32'(d0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
